mem_port_arbiter: RTL

//  Shares the single 32-bit memory port between instruction fetch (IF) and load/store (LS).
//  - Sequences each transaction and drives addr_sel, the select of the 32-bit 2:1 address/data mux in front of memory.
//  - LS has priority; a streak limiter prevents IF starvation.
//  - A watchdog terminates transactions the memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: load/store has priority over instruction fetch,
// a streak limiter guarantees fetch progress, and a watchdog aborts unacknowledged transfers.
module mem_port_arbiter #(
   parameter int LS_STREAK_MAX = 4,
   parameter int TIMEOUT       = 16,
   parameter int CNT_W         = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [3:0]  ls_be,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        addr_sel,
   output logic        err
);
   localparam int SW = $clog2(LS_STREAK_MAX + 1);

   typedef enum logic [1:0] {IDLE, OWN_IF, OWN_LS} state_t;

   state_t          r_state, w_next;
   logic [SW-1:0]   r_streak;
   logic [CNT_W-1:0] r_wdog;
   logic            r_we, r_sel;
   logic [3:0]      r_be;
   logic [31:0]     r_addr, r_wdata;
   logic            w_own, w_expired, w_finish, w_grant_ls, w_grant_if, w_streak_full;

   always_comb begin
      w_next        = r_state;
      w_grant_ls    = 1'b0;
      w_grant_if    = 1'b0;
      w_own         = (r_state != IDLE);
      w_streak_full = (r_streak == SW'(LS_STREAK_MAX));
      w_expired     = (r_wdog == CNT_W'(TIMEOUT - 1));
      w_finish      = w_own && (mem_ack || w_expired);
      case (r_state)
         IDLE: begin
            // Fetch wins only once load/store has used up its streak while fetch waits
            if (ls_req && !(if_req && w_streak_full)) begin
               w_grant_ls = 1'b1;
               w_next     = OWN_LS;
            end else if (if_req) begin
               w_grant_if = 1'b1;
               w_next     = OWN_IF;
            end
         end
         OWN_IF, OWN_LS: if (w_finish) w_next = IDLE;
         default:        w_next = IDLE;
      endcase

      // A reset cycle suppresses completion of the transfer it is aborting
      mem_req  = w_own;
      if_done  = (r_state == OWN_IF) && w_finish && !rst;
      ls_done  = (r_state == OWN_LS) && w_finish && !rst;
      err      = w_own && w_expired && !mem_ack && !rst;
      if_rdata = (if_done && mem_ack) ? mem_rdata : 32'h0;
      ls_rdata = (ls_done && mem_ack) ? mem_rdata : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_streak <= '0;
         r_wdog   <= '0;
         r_we     <= 1'b0;
         r_be     <= 4'h0;
         r_addr   <= 32'h0;
         r_wdata  <= 32'h0;
         r_sel    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_own) r_wdog <= w_finish ? '0 : r_wdog + 1'b1;
         if (w_grant_ls) begin
            r_we    <= ls_we;
            r_be    <= ls_be;
            r_addr  <= ls_addr;
            r_wdata <= ls_wdata;
            r_sel   <= 1'b1;
            if (!if_req)            r_streak <= '0;
            else if (!w_streak_full) r_streak <= r_streak + 1'b1;
         end else if (w_grant_if) begin
            r_we     <= 1'b0;
            r_be     <= 4'hF;
            r_addr   <= if_addr;
            r_wdata  <= 32'h0;
            r_sel    <= 1'b0;
            r_streak <= '0;
         end
      end
   end

   assign mem_we    = r_we;
   assign mem_be    = r_be;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign addr_sel  = r_sel;

endmodule
